uart_tx_sched: RTL
==================

# uart_tx_sched

Transmit-side scheduler for the APB UART, in the uart_clk domain between the TX async FIFO read port and the tx_shift serializer. It decides when a FIFO byte or an XON/XOFF control character is handed to the shifter. It enforces software flow control (XON/XOFF) and optional hardware CTS gating, and counts transmitted data bytes.

## Interface
- DATA_WIDTH, 8, character width
- XON_CHAR, 8'h11, character sent to resume the remote transmitter
- XOFF_CHAR, 8'h13, character sent to pause the remote transmitter
- CNT_WIDTH, 16, width of the transmitted-byte counter

- uart_clk  in  1  clock; all logic on its rising edge
- PRESETn  in  1  reset, asynchronous, active-low
- tx_en  in  1  transmit enable (control_reg TX_EN, quasi-static)
- sw_flow_en  in  1  XON/XOFF flow-control enable
- fifo_empty  in  1  TX FIFO empty
- fifo_rd_en  out  1  one-cycle FIFO pop
- fifo_rd_data  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en
- shift_idle  in  1  tx_shift idle
- shift_load  out  1  one-cycle load strobe to tx_shift
- shift_data  out  DATA_WIDTH  character to load, valid with shift_load
- rx_throttle  in  1  level: local RX FIFO at or above the flow-control threshold
- rx_xoff_seen  in  1  pulse: XOFF received from the remote end
- rx_xon_seen  in  1  pulse: XON received from the remote end
- cts_n  in  1  asynchronous clear-to-send, active-low
- remote_paused  out  1  data transmission paused by a remote XOFF
- xoff_sent  out  1  the last control character sent was XOFF
- tx_byte_cnt  out  CNT_WIDTH  count of data bytes loaded, wraps

## Operation
- States: IDLE, FETCH, LOAD, GUARD, BUSY.
- In IDLE, with shift_idle=1 and tx_en=1, the block arbitrates in fixed priority:
  - Control pending (sw_flow_en=1 and rx_throttle != xoff_sent): go to LOAD with shift_data = XOFF_CHAR if rx_throttle=1, else XON_CHAR. Update xoff_sent on load.
  - Otherwise data eligible (fifo_empty=0, remote_paused=0, and CTS asserted when configured): assert fifo_rd_en and go to FETCH.
- FETCH -> LOAD. fifo_rd_data is captured into shift_data.
- LOAD: assert shift_load for one cycle, then go to GUARD. Increment tx_byte_cnt only for data; the counter wraps from all-ones to 0.
- GUARD: one cycle with shift_idle ignored, then go to BUSY.
- BUSY: go to IDLE when shift_idle=1.
- Control characters bypass remote_paused and CTS. Data never bypasses them.
- remote_paused:
  - rx_xoff_seen sets it.
  - rx_xon_seen clears it; if both arrive in the same cycle, XON wins.
  - sw_flow_en=0 forces it to 0 and suppresses control characters.
- rx_throttle toggling several times before a control slot is free sends at most one character, reflecting the current level. No redundant XON/XOFF is sent.
- tx_en deasserted mid-character: the current character completes, then nothing new starts.
- A FIFO byte, once popped, is always loaded. A state change during FETCH does not drop it.

## Timing
- Reset values:
  - state IDLE
  - fifo_rd_en 0, shift_load 0, shift_data 0
  - remote_paused 0, xoff_sent 0, tx_byte_cnt 0
- Data latency: fifo_rd_en at cycle N, shift_load at N+2. Cycle N requires IDLE with all conditions true.
- Control latency: shift_load one cycle after the IDLE decision.
- Minimum spacing between consecutive shift_load pulses: 4 cycles, plus the shifter's busy time.
- rx_xoff_seen / rx_xon_seen take effect on the next arbitration cycle.
- Reset mid-operation aborts immediately. No pending pop or load survives reset.

## Configuration
- UART_HW_FLOW_EN defined:
  - cts_n passes through a 2-flop synchronizer.
  - A synchronized cts_n=1 blocks the start of data, checked only in IDLE.
  - CTS latency is 2 cycles.
- UART_HW_FLOW_EN undefined: the cts_n port exists but is ignored, and no synchronizer is built.

## Structure
- uart_pkg holds:
  - XON/XOFF default constants
  - the scheduler state enum
  - CNT_WIDTH default
- One sub-module: uart_sync2, a generic 2-flop synchronizer with reset value 1 for cts_n. It is instantiated only under UART_HW_FLOW_EN.

## Test plan
- Data path: tx_en=1, FIFO holds 8'hA5, 8'h3C, shift_idle modelled 10 cycles busy per character -> two loads of A5 then 3C, each 2 cycles after its pop, and tx_byte_cnt=2.
- Control priority: data pending and rx_throttle rises with sw_flow_en=1 -> 8'h13 loaded first with xoff_sent=1. rx_throttle then falls -> 8'h11 loaded before the next data byte, and tx_byte_cnt is unchanged by either control load.
- Remote pause: rx_xoff_seen pulse with FIFO non-empty -> no fifo_rd_en. rx_xoff_seen and rx_xon_seen in the same cycle -> remote_paused=0 and data resumes.
- Throttle glitch: rx_throttle 0->1->0 while BUSY with xoff_sent=0 -> no control character is sent.
- CTS (UART_HW_FLOW_EN): cts_n=1 blocks pops; cts_n=0 -> fifo_rd_en 2-3 cycles later. Without the macro, cts_n=1 has no effect.
- Counter wrap and reset: preload 16'hFFFF data loads -> the next load gives 0. PRESETn low during FETCH -> all outputs at reset values and no load issued.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants and types for the APB UART transmit path:
//                default XON/XOFF characters, default character and counter
//                widths, and the transmit scheduler state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned c_data_width = 8;
    localparam logic [7:0]  c_xon_char   = 8'h11;
    localparam logic [7:0]  c_xoff_char  = 8'h13;
    localparam int unsigned c_cnt_width  = 16;

    // Transmit scheduler states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_GUARD = 3'd3,
        ST_BUSY  = 3'd4
    } sched_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync2
//  Description : Generic two-flop synchronizer for a single asynchronous
//                level into the uart_clk domain.
//  Ports       : uart_clk  - destination clock
//                PRESETn   - asynchronous active-low reset
//                async_in  - asynchronous input level
//                sync_out  - synchronized level (2 cycle latency)
//  Parameters  : RESET_VAL - value both flops take during reset
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic uart_clk,
    input  logic PRESETn,
    input  logic async_in,
    output logic sync_out
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge uart_clk or negedge PRESETn) begin
        if (!PRESETn) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
        end
    end

    assign sync_out = r_sync;

endmodule : uart_sync2
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_sched
//  Description : Transmit scheduler between the TX FIFO read port and the
//                tx_shift serializer. Chooses between a pending XON/XOFF
//                control character (highest priority) and the next FIFO
//                data byte, applies remote XOFF pause and optional CTS
//                gating to data only, and counts data bytes loaded.
//  Ports       : uart_clk/PRESETn        - clock, async active-low reset
//                tx_en, sw_flow_en       - transmit / XON-XOFF enables
//                fifo_empty/rd_en/rd_data- TX FIFO read port
//                shift_idle/load/data    - tx_shift handshake
//                rx_throttle             - local RX wants remote paused
//                rx_xoff_seen/xon_seen   - remote flow-control pulses
//                cts_n                   - async clear-to-send, active-low
//                remote_paused, xoff_sent, tx_byte_cnt - status
//  Config      : UART_HW_FLOW_EN - when defined, cts_n is synchronized and
//                a deasserted CTS blocks the start of data bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH = c_data_width,
    parameter logic [DATA_WIDTH-1:0]  XON_CHAR   = DATA_WIDTH'(c_xon_char),
    parameter logic [DATA_WIDTH-1:0]  XOFF_CHAR  = DATA_WIDTH'(c_xoff_char),
    parameter int unsigned            CNT_WIDTH  = c_cnt_width
) (
    input  logic                  uart_clk,
    input  logic                  PRESETn,
    input  logic                  tx_en,
    input  logic                  sw_flow_en,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  shift_idle,
    output logic                  shift_load,
    output logic [DATA_WIDTH-1:0] shift_data,
    input  logic                  rx_throttle,
    input  logic                  rx_xoff_seen,
    input  logic                  rx_xon_seen,
    input  logic                  cts_n,
    output logic                  remote_paused,
    output logic                  xoff_sent,
    output logic [CNT_WIDTH-1:0]  tx_byte_cnt
);

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;
    logic                  r_is_ctrl;      // character in flight is XON/XOFF
    logic                  r_ctrl_xoff;    // control character in flight is XOFF
    logic [DATA_WIDTH-1:0] r_shift_data;
    logic                  r_remote_paused;
    logic                  r_xoff_sent;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic w_cts_ok;
    logic w_arb;
    logic w_ctrl_pending;
    logic w_ctrl_go;
    logic w_data_go;
    logic w_rd_en;
    logic w_load;

`ifdef UART_HW_FLOW_EN
    logic w_cts_n_sync;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_cts_sync (
        .uart_clk (uart_clk),
        .PRESETn  (PRESETn),
        .async_in (cts_n),
        .sync_out (w_cts_n_sync)
    );

    assign w_cts_ok = ~w_cts_n_sync;
`else
    // cts_n is present for pin compatibility only; it never gates data here.
    assign w_cts_ok = 1'b1 | cts_n;
`endif

    // A control character is owed only when the throttle level disagrees
    // with what the remote end was last told, so glitches that settle back
    // before a slot frees up produce nothing.
    assign w_ctrl_pending = sw_flow_en && (rx_throttle != r_xoff_sent);
    assign w_arb          = (r_state == ST_IDLE) && shift_idle && tx_en;
    assign w_ctrl_go      = w_arb && w_ctrl_pending;
    assign w_data_go      = w_arb && !w_ctrl_pending && !fifo_empty &&
                            !r_remote_paused && w_cts_ok;

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ctrl_go) begin
                    w_state_nxt = ST_LOAD;
                end else if (w_data_go) begin
                    w_rd_en     = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = ST_GUARD;
            end
            // shift_idle may still read 1 the cycle after the load strobe
            ST_GUARD: w_state_nxt = ST_BUSY;
            ST_BUSY: begin
                if (shift_idle) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge uart_clk or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state      <= ST_IDLE;
            r_is_ctrl    <= 1'b0;
            r_ctrl_xoff  <= 1'b0;
            r_shift_data <= '0;
            r_xoff_sent  <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ctrl_go) begin
                r_is_ctrl    <= 1'b1;
                r_ctrl_xoff  <= rx_throttle;
                r_shift_data <= rx_throttle ? XOFF_CHAR : XON_CHAR;
            end else if (w_data_go) begin
                r_is_ctrl <= 1'b0;
            end
            // The popped byte is always carried into LOAD; nothing but reset
            // can divert FETCH.
            if (r_state == ST_FETCH) begin
                r_shift_data <= fifo_rd_data;
            end
            if (r_state == ST_LOAD) begin
                if (r_is_ctrl) begin
                    r_xoff_sent <= r_ctrl_xoff;
                end else begin
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

    // XON wins over a simultaneous XOFF; disabling flow control clears it.
    always_ff @(posedge uart_clk or negedge PRESETn) begin
        if (!PRESETn) begin
            r_remote_paused <= 1'b0;
        end else if (!sw_flow_en || rx_xon_seen) begin
            r_remote_paused <= 1'b0;
        end else if (rx_xoff_seen) begin
            r_remote_paused <= 1'b1;
        end
    end

    // The pop strobe is combinational from IDLE; mask it while reset is held
    // so no byte is lost from the FIFO during reset.
    assign fifo_rd_en    = w_rd_en & PRESETn;
    assign shift_load    = w_load;
    assign shift_data    = r_shift_data;
    assign remote_paused = r_remote_paused;
    assign xoff_sent     = r_xoff_sent;
    assign tx_byte_cnt   = r_cnt;

endmodule : uart_tx_sched
`default_nettype wire
